// File: rtl/window_line_buffer.sv
// window_line_buffer
//   Sliding ROWS x COLS neighbourhood generator for a raster pixel stream.
//   ROWS-1 circular line delays provide the vertically adjacent pixels; each
//   row then passes through a COLS-deep shift register. The window, its
//   validity flag and the coordinates of its newest pixel are registered, so
//   data_in appears in the window one clock after it is accepted.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   write_en     pixel valid; data_in accepted on every edge where high
//   frame_start  marks data_in as pixel (0,0) of a new frame (with write_en)
//   data_in      pixel in raster order
//   window       element (r,c) at [(r*COLS+c)*DATA_W +: DATA_W], r=0 top row,
//                c=0 leftmost column
//   out_valid    window holds ROWS x COLS real pixels of one frame
//   out_col      column of element (ROWS-1,COLS-1)
//   out_row      row of element (ROWS-1,COLS-1)
module window_line_buffer #(
  parameter int DATA_W   = 32,
  parameter int LINE_LEN = 80,
  parameter int ROWS     = 3,
  parameter int COLS     = 3,
  parameter int CNT_W    = 7,
  parameter int ROW_W    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic                          frame_start,
  input  logic [DATA_W-1:0]             data_in,
  output logic [ROWS*COLS*DATA_W-1:0]   window,
  output logic                          out_valid,
  output logic [CNT_W-1:0]              out_col,
  output logic [ROW_W-1:0]              out_row
);

  localparam int               AW       = $clog2(LINE_LEN);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_COL  = CNT_W'(COLS - 1);
  localparam logic [ROW_W-1:0] MIN_ROW  = ROW_W'(ROWS - 1);

  typedef logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] win_t;

  logic [CNT_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic             accept, win_en;
  logic [AW-1:0]    addr;

  logic [DATA_W-1:0]              line_mem_q [ROWS-1][LINE_LEN];
  logic [ROWS-2:0][DATA_W-1:0]    rd_data;
  logic [ROWS-2:0][DATA_W-1:0]    wr_data;

  win_t             sr_q, sr_d;
  win_t             win_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] out_col_q;
  logic [ROW_W-1:0] out_row_q;

  assign accept = write_en & ~rst;

  // A frame_start pixel is (0,0) regardless of where the counters are.
  assign cur_col = frame_start ? '0 : col_q;
  assign cur_row = frame_start ? '0 : row_q;

  // The column counter doubles as the shared line-delay pointer, so a line
  // delay always returns the same column one line earlier.
  assign addr = cur_col[AW-1:0];

  // Only neighbourhoods lying entirely inside the current frame and line are
  // valid; stale line/shift contents are masked by this test alone.
  assign win_en = accept && (cur_col >= MIN_COL) && (cur_row >= MIN_ROW);

  always_comb begin
    col_d = cur_col + CNT_W'(1);
    row_d = cur_row;
    if (cur_col == LAST_COL) begin
      col_d = '0;
      if (!(&cur_row)) row_d = cur_row + ROW_W'(1);
    end
  end

  // Line delays are chained: the newest delay stores data_in, each older one
  // stores what the delay below it just returned.
  always_comb begin
    for (int r = 0; r < ROWS - 1; r++) rd_data[r] = line_mem_q[r][addr];
    for (int r = 0; r < ROWS - 2; r++) wr_data[r] = rd_data[r+1];
    wr_data[ROWS-2] = data_in;
  end

  always_comb begin
    sr_d = sr_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) sr_d[r][c] = sr_q[r][c+1];
    end
    for (int r = 0; r < ROWS - 1; r++) sr_d[r][COLS-1] = rd_data[r];
    sr_d[ROWS-1][COLS-1] = data_in;
  end

  // Stage boundary: line memories and shift registers (no reset, masked by
  // the counters instead).
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < ROWS - 1; r++) line_mem_q[r][addr] <= wr_data[r];
      sr_q <= sr_d;
    end
  end

  // Stage boundary: counters and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
    end else begin
      out_valid_q <= win_en;
      if (write_en) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (win_en) begin
        win_q     <= sr_d;
        out_col_q <= cur_col;
        out_row_q <= cur_row;
      end
    end
  end

  assign window    = win_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;

endmodule
